// File: rtl/rf_sequencer.sv
// rf_sequencer: four-state (IDLE/READ/EXEC/WRITE) micro-sequencer that drives
// the read and write sides of an external four-entry register file and
// contains the ALU for an 8-opcode instruction set.
// Optional build macro: RF_SEQ_FLAGS_EN adds registered zero/carry flag
// outputs, updated at the edge that closes WRITE.
module rf_sequencer #(
    parameter int REGISTER_LEN = 10
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [2:0]              op,
    input  logic [1:0]              dst,
    input  logic [1:0]              srca,
    input  logic [1:0]              srcb,
    input  logic [REGISTER_LEN-1:0] imm,
    output logic                    busy,
    output logic                    done,
    output logic                    rf_we,
    output logic [1:0]              rf_wa,
    output logic [REGISTER_LEN-1:0] rf_din,
    output logic                    rf_rae,
    output logic [1:0]              rf_raa,
    output logic                    rf_rbe,
    output logic [1:0]              rf_rbb,
    input  logic [REGISTER_LEN-1:0] rf_a,
    input  logic [REGISTER_LEN-1:0] rf_b
`ifdef RF_SEQ_FLAGS_EN
    ,
    output logic                    zero,
    output logic                    carry
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        OP_LOAD = 3'b000,
        OP_MOV  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_XOR  = 3'b110,
        OP_NOT  = 3'b111
    } op_e;

    state_e                  state_q;
    op_e                     op_q;
    logic [1:0]              dst_q;
    logic                    ready_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    rf_we_q;
    logic [1:0]              rf_wa_q;
    logic [REGISTER_LEN-1:0] rf_din_q;   // doubles as the result register
    logic                    rf_rae_q;
    logic [1:0]              rf_raa_q;   // doubles as the latched srca
    logic                    rf_rbe_q;
    logic [1:0]              rf_rbb_q;   // doubles as the latched srcb
    logic [REGISTER_LEN-1:0] alu_res;
`ifdef RF_SEQ_FLAGS_EN
    logic                    alu_carry;
    logic                    carry_q;
    logic                    zero_flag_q;
    logic                    carry_flag_q;
`endif

    // Only two-operand ops fetch the second source.
    function automatic logic uses_b(input logic [2:0] opcode);
        return (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND) ||
               (opcode == OP_OR)  || (opcode == OP_XOR);
    endfunction

    // ALU: result from the register file read data, truncated to REGISTER_LEN.
    always_comb begin
        // NOTE: default assignment first so no path leaves alu_res unassigned (no latch).
        alu_res = '0;
        unique case (op_q)
            OP_MOV:  alu_res = rf_a;
            OP_ADD:  alu_res = rf_a + rf_b;
            OP_SUB:  alu_res = rf_a - rf_b;
            OP_AND:  alu_res = rf_a & rf_b;
            OP_OR:   alu_res = rf_a | rf_b;
            OP_XOR:  alu_res = rf_a ^ rf_b;
            OP_NOT:  alu_res = ~rf_a;
            default: alu_res = '0;   // LOAD never passes through EXEC
        endcase
    end

`ifdef RF_SEQ_FLAGS_EN
    // Carry/borrow: an unsigned add wrapped iff the truncated sum is below a.
    always_comb begin
        alu_carry = 1'b0;
        if (op_q == OP_ADD) begin
            alu_carry = (alu_res < rf_a);
        end else if (op_q == OP_SUB) begin
            alu_carry = (rf_a < rf_b);
        end
    end
`endif

    // Sequencer FSM with registered outputs; an async reset aborts any operation.
    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_LOAD;
            dst_q    <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rf_we_q  <= 1'b0;
            rf_wa_q  <= '0;
            rf_din_q <= '0;
            rf_rae_q <= 1'b0;
            rf_raa_q <= '0;
            rf_rbe_q <= 1'b0;
            rf_rbb_q <= '0;
`ifdef RF_SEQ_FLAGS_EN
            carry_q      <= 1'b0;
            zero_flag_q  <= 1'b0;
            carry_flag_q <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            done_q   <= 1'b0;
            rf_we_q  <= 1'b0;
            rf_rae_q <= 1'b0;
            rf_rbe_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid && ready_q) begin
                        op_q    <= op_e'(op);
                        dst_q   <= dst;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (op == OP_LOAD) begin
                            state_q  <= S_WRITE;
                            rf_we_q  <= 1'b1;
                            rf_wa_q  <= dst;
                            rf_din_q <= imm;
                            done_q   <= 1'b1;
`ifdef RF_SEQ_FLAGS_EN
                            carry_q  <= 1'b0;
`endif
                        end else begin
                            state_q  <= S_READ;
                            rf_rae_q <= 1'b1;
                            rf_raa_q <= srca;
                            if (uses_b(op)) begin
                                rf_rbe_q <= 1'b1;
                                rf_rbb_q <= srcb;
                            end
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                S_READ: begin
                    // Register file returns rf_a/rf_b at this closing edge.
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    state_q  <= S_WRITE;
                    rf_we_q  <= 1'b1;
                    rf_wa_q  <= dst_q;
                    rf_din_q <= alu_res;
                    done_q   <= 1'b1;
`ifdef RF_SEQ_FLAGS_EN
                    carry_q  <= alu_carry;
`endif
                end
                S_WRITE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
`ifdef RF_SEQ_FLAGS_EN
                    zero_flag_q  <= (rf_din_q == '0);
                    carry_flag_q <= carry_q;
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign rf_we     = rf_we_q;
    assign rf_wa     = rf_wa_q;
    assign rf_din    = rf_din_q;
    assign rf_rae    = rf_rae_q;
    assign rf_raa    = rf_raa_q;
    assign rf_rbe    = rf_rbe_q;
    assign rf_rbb    = rf_rbb_q;
`ifdef RF_SEQ_FLAGS_EN
    assign zero      = zero_flag_q;
    assign carry     = carry_flag_q;
`endif

endmodule

// File: tb/tb_rf_sequencer.sv
// Testbench for rf_sequencer (REGISTER_LEN=10) with an attached register file
// model and a scoreboard of expected write-backs.
module tb_rf_sequencer;

    localparam int W = 10;

    logic         Clock;
    logic         Reset;
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   op;
    logic [1:0]   dst, srca, srcb;
    logic [W-1:0] imm;
    logic         busy, done;
    logic         rf_we, rf_rae, rf_rbe;
    logic [1:0]   rf_wa, rf_raa, rf_rbb;
    logic [W-1:0] rf_din, rf_a, rf_b;
`ifdef RF_SEQ_FLAGS_EN
    logic         zero, carry;
`endif

    rf_sequencer #(.REGISTER_LEN(W)) dut (
        .Clock(Clock), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .op(op), .dst(dst), .srca(srca), .srcb(srcb), .imm(imm),
        .busy(busy), .done(done),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_din(rf_din),
        .rf_rae(rf_rae), .rf_raa(rf_raa), .rf_rbe(rf_rbe), .rf_rbb(rf_rbb),
        .rf_a(rf_a), .rf_b(rf_b)
`ifdef RF_SEQ_FLAGS_EN
        , .zero(zero), .carry(carry)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Register file model: registered read data, no reset of contents.
    logic [W-1:0] rf_mem [4] = '{default: '0};
    always @(posedge Clock) begin
        if (rf_we)  rf_mem[rf_wa] <= rf_din;
        if (rf_rae) rf_a <= rf_mem[rf_raa];
        if (rf_rbe) rf_b <= rf_mem[rf_rbb];
    end

    typedef struct {
        logic [2:0]   op;
        logic [1:0]   dst;
        logic [1:0]   sa;
        logic [1:0]   sb;
        logic [W-1:0] val;
        logic         cy;
        int           lat;
    } exp_t;

    exp_t         sb_q[$];
    logic [W-1:0] exp_regs [4] = '{default: '0};
    int           tests = 0;
    int           fails = 0;

    function automatic logic two_src(input logic [2:0] o);
        return (o >= 3'd2) && (o <= 3'd6);
    endfunction

    // Reference result {carry, value} computed with wide integer arithmetic.
    function automatic logic [W:0] model(input logic [2:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic [W-1:0] im);
        int ai, bi, r;
        ai = int'(a);
        bi = int'(b);
        case (o)
            3'd0: r = int'(im);
            3'd1: r = ai;
            3'd2: r = ai + bi;
            3'd3: r = (ai < bi) ? (ai - bi + 2048) : (ai - bi);
            3'd4: r = int'(a & b);
            3'd5: r = int'(a | b);
            3'd6: r = int'(a ^ b);
            default: r = 1023 - ai;
        endcase
        return r[W:0];
    endfunction

    task automatic push_exp(input logic [2:0] o, input logic [1:0] d, input logic [1:0] sa,
                            input logic [1:0] sbb, input logic [W-1:0] im);
        exp_t e;
        logic [W:0] m;
        m = model(o, exp_regs[sa], exp_regs[sbb], im);
        e.op  = o;
        e.dst = d;
        e.sa  = sa;
        e.sb  = sbb;
        e.val = m[W-1:0];
        e.cy  = (o == 3'd2 || o == 3'd3) ? m[W] : 1'b0;
        e.lat = (o == 3'd0) ? 1 : 3;
        sb_q.push_back(e);
    endtask

    // Called just after the transfer edge: walks the cycles up to write-back.
    task automatic wait_wb();
        exp_t e;
        tests++;
        if (sb_q.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_empty: got 0 entries, expected 1");
            return;
        end
        e = sb_q.pop_front();
        for (int n = 1; n <= e.lat; n++) begin
            @(negedge Clock);
            if (n < e.lat) begin
                tests++;
                if ({rf_we, req_ready, busy} !== 3'b001) begin
                    fails++;
                    $display("FAIL busy_cycle%0d: got we/ready/busy=%b, expected 001", n, {rf_we, req_ready, busy});
                end
            end
            if (n == 1 && e.lat == 3) begin
                tests++;
                if ({rf_rae, rf_raa, rf_rbe} !== {1'b1, e.sa, two_src(e.op)}) begin
                    fails++;
                    $display("FAIL read_side: got rae/raa/rbe=%b/%0d/%b, expected 1/%0d/%b",
                             rf_rae, rf_raa, rf_rbe, e.sa, two_src(e.op));
                end
                if (two_src(e.op)) begin
                    tests++;
                    if (rf_rbb !== e.sb) begin
                        fails++;
                        $display("FAIL read_rbb: got %0d, expected %0d", rf_rbb, e.sb);
                    end
                end
            end
            if (n == e.lat) begin
                tests++;
                if ({rf_we, done, rf_wa, rf_din} !== {1'b1, 1'b1, e.dst, e.val}) begin
                    fails++;
                    $display("FAIL writeback op%0d: got we=%b done=%b wa=%0d din=%h, expected we=1 done=1 wa=%0d din=%h",
                             e.op, rf_we, done, rf_wa, rf_din, e.dst, e.val);
                end
            end
        end
        exp_regs[e.dst] = e.val;
        @(negedge Clock);
        tests++;
        if ({done, rf_we, busy, req_ready} !== 4'b0001) begin
            fails++;
            $display("FAIL after_write: got done/we/busy/ready=%b, expected 0001", {done, rf_we, busy, req_ready});
        end
`ifdef RF_SEQ_FLAGS_EN
        tests++;
        if ({zero, carry} !== {(e.val == '0), e.cy}) begin
            fails++;
            $display("FAIL flags op%0d: got zero/carry=%b%b, expected %b%b", e.op, zero, carry, (e.val == '0), e.cy);
        end
`endif
    endtask

    // Issue one request, scramble the request inputs after transfer, check write-back.
    task automatic run_op(input logic [2:0] o, input logic [1:0] d, input logic [1:0] sa,
                          input logic [1:0] sbb, input logic [W-1:0] im);
        int guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge Clock);
            guard++;
        end
        tests++;
        if (!req_ready) begin
            fails++;
            $display("FAIL ready_timeout: got req_ready=0, expected 1");
            return;
        end
        push_exp(o, d, sa, sbb, im);
        op = o; dst = d; srca = sa; srcb = sbb; imm = im;
        req_valid = 1'b1;
        @(posedge Clock);
        #1;
        req_valid = 1'b0;
        op = ~o; dst = ~d; srca = ~sa; srcb = ~sbb; imm = ~im;
        wait_wb();
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if ({req_ready, busy, done, rf_we, rf_rae, rf_rbe} !== 6'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b, expected 000000", {req_ready, busy, done, rf_we, rf_rae, rf_rbe});
        end
        tests++;
        if ({rf_wa, rf_raa, rf_rbb, rf_din} !== 16'h0) begin
            fails++;
            $display("FAIL reset_data: got %h, expected 0000", {rf_wa, rf_raa, rf_rbb, rf_din});
        end
        repeat (2) @(negedge Clock);
        tests++;
        if (req_ready !== 1'b0) begin
            fails++;
            $display("FAIL ready_in_reset: got %b, expected 0", req_ready);
        end
        Reset = 1'b0;
        @(negedge Clock);
        tests++;
        if ({req_ready, busy} !== 2'b10) begin
            fails++;
            $display("FAIL ready_after_reset: got ready/busy=%b, expected 10", {req_ready, busy});
        end
    endtask

    task automatic test_load();
        run_op(3'd0, 2'd1, 2'd0, 2'd0, 10'h3FF);
        run_op(3'd0, 2'd2, 2'd0, 2'd0, 10'h001);
        run_op(3'd0, 2'd0, 2'd0, 2'd0, 10'h000);
    endtask

    task automatic test_arith();
        run_op(3'd2, 2'd3, 2'd1, 2'd2, 10'h000);   // 0x3FF + 1 wraps to 0
        run_op(3'd3, 2'd0, 2'd2, 2'd1, 10'h000);   // 1 - 0x3FF = 0x002 with borrow
        run_op(3'd7, 2'd3, 2'd2, 2'd0, 10'h000);   // ~1 = 0x3FE, no second read
        run_op(3'd3, 2'd2, 2'd1, 2'd0, 10'h000);   // 0x3FF - 2, no borrow
    endtask

    task automatic test_logic();
        run_op(3'd0, 2'd2, 2'd0, 2'd0, 10'h2A5);
        run_op(3'd4, 2'd0, 2'd1, 2'd2, 10'h000);
        run_op(3'd5, 2'd1, 2'd2, 2'd3, 10'h000);
        run_op(3'd6, 2'd3, 2'd2, 2'd1, 10'h000);
        run_op(3'd1, 2'd0, 2'd3, 2'd0, 10'h000);
    endtask

    task automatic test_alias();
        run_op(3'd0, 2'd1, 2'd0, 2'd0, 10'h100);
        run_op(3'd2, 2'd1, 2'd1, 2'd1, 10'h000);
        tests++;
        if (rf_mem[1] !== 10'h200) begin
            fails++;
            $display("FAIL alias_r1: got %h, expected 200", rf_mem[1]);
        end
    endtask

    // req_valid stays high across a busy op while op/imm change underneath it.
    task automatic test_back_to_back();
        push_exp(3'd2, 2'd2, 2'd1, 2'd3, 10'h000);
        op = 3'd2; dst = 2'd2; srca = 2'd1; srcb = 2'd3; imm = 10'h0AA;
        req_valid = 1'b1;
        @(posedge Clock);
        #1;
        op = 3'd0; dst = 2'd3; imm = 10'h155;
        wait_wb();
        push_exp(3'd0, 2'd3, 2'd0, 2'd0, 10'h155);
        @(posedge Clock);
        #1;
        req_valid = 1'b0;
        wait_wb();
    endtask

    task automatic test_reset_exec();
        op = 3'd3; dst = 2'd0; srca = 2'd3; srcb = 2'd2; imm = 10'h000;
        req_valid = 1'b1;
        @(posedge Clock);
        #1;
        req_valid = 1'b0;
        @(negedge Clock);
        tests++;
        if (rf_rae !== 1'b1) begin
            fails++;
            $display("FAIL abort_read: got rf_rae=%b, expected 1", rf_rae);
        end
        @(posedge Clock);
        #2;
        Reset = 1'b1;
        #1;
        tests++;
        if ({req_ready, busy, done, rf_we, rf_rae, rf_rbe} !== 6'b0) begin
            fails++;
            $display("FAIL abort_ctrl: got %b, expected 000000", {req_ready, busy, done, rf_we, rf_rae, rf_rbe});
        end
        tests++;
        if ({rf_wa, rf_raa, rf_rbb, rf_din} !== 16'h0) begin
            fails++;
            $display("FAIL abort_data: got %h, expected 0000", {rf_wa, rf_raa, rf_rbb, rf_din});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            tests++;
            if (rf_we !== 1'b0) begin
                fails++;
                $display("FAIL abort_we%0d: got %b, expected 0", i, rf_we);
            end
        end
        Reset = 1'b0;
        @(negedge Clock);
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL abort_ready: got %b, expected 1", req_ready);
        end
        for (int r = 0; r < 4; r++) begin
            tests++;
            if (rf_mem[r] !== exp_regs[r]) begin
                fails++;
                $display("FAIL abort_reg%0d: got %h, expected %h", r, rf_mem[r], exp_regs[r]);
            end
        end
        run_op(3'd1, 2'd1, 2'd3, 2'd0, 10'h000);
    endtask

    initial begin
        Reset = 1'b1;
        req_valid = 1'b0;
        op = '0; dst = '0; srca = '0; srcb = '0; imm = '0;
        test_reset();
        test_load();
        test_arith();
        test_logic();
        test_alias();
        test_back_to_back();
        test_reset_exec();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected finish before 100000");
        $fatal(1);
    end

endmodule

// File: doc/rf_sequencer.md
RF_SEQUENCER -- requirements
Module: rf_sequencer

Interface
REQ-001 SHALL have parameter: REGISTER_LEN, default 10, data width of the register file and ALU.
REQ-002 SHALL have port: Clock  in  1  the only clock; all state changes on its rising edge.
REQ-003 SHALL have port: Reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: req_valid  in  1  operation request present.
REQ-005 SHALL have port: req_ready  out  1  sequencer can accept a request.
REQ-006 SHALL have port: op  in  3  opcode: 000 LOAD, 001 MOV, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR, 111 NOT.
REQ-007 SHALL have port: dst / srca / srcb  in  2 each  destination and source register addresses.
REQ-008 SHALL have port: imm  in  REGISTER_LEN  immediate for LOAD.
REQ-009 SHALL have port: busy  out  1  high in any state other than IDLE.
REQ-010 SHALL have port: done  out  1  one-cycle pulse in the write-back cycle.
REQ-011 SHALL have ports rf_we out 1, rf_wa out 2, and rf_din out REGISTER_LEN, driving the register file write side.
REQ-012 SHALL have ports rf_rae out 1, rf_raa out 2, rf_rbe out 1, and rf_rbb out 2, driving the register file read side.
REQ-013 SHALL have ports rf_a in REGISTER_LEN and rf_b in REGISTER_LEN, the registered read data returned by the register file one edge after the read enables.

Function
REQ-014 SHALL implement the states IDLE, READ, EXEC and WRITE.
REQ-015 SHALL drive req_ready=1 only in IDLE, and SHALL transfer a request on a rising edge with req_valid=1 and req_ready=1.
REQ-016 SHALL latch op, dst, srca, srcb and imm at transfer; later changes to those inputs SHALL have no effect on the operation in progress.
REQ-017 SHALL ignore req_valid while busy, with no queuing.
REQ-018 SHALL move from IDLE to WRITE on transfer when op is LOAD, and SHALL move from IDLE to READ on transfer for all other opcodes.
REQ-019 SHALL, in READ, drive rf_rae=1 with rf_raa=srca, and SHALL drive rf_rbe=1 with rf_rbb=srcb only for ADD, SUB, AND, OR and XOR; the next state SHALL be EXEC.
REQ-020 SHALL, in EXEC, compute the result from rf_a and rf_b, register it at the closing edge, and move to WRITE.
REQ-021 SHALL compute the results as follows: MOV=a; ADD=a+b; SUB=a-b; AND, OR and XOR bitwise; NOT=~a; LOAD=imm.
REQ-022 SHALL truncate every result to REGISTER_LEN bits, so that wrap-around is modulo 2^REGISTER_LEN.
REQ-023 SHALL, in WRITE, drive rf_we=1, rf_wa=dst, rf_din=result and done=1, then return to IDLE.
REQ-024 SHALL outside WRITE drive rf_we=0 and done=0, and SHALL outside READ drive rf_rae=0 and rf_rbe=0.
REQ-025 SHALL place write-back in the third cycle after transfer for non-LOAD ops, and in the first cycle after transfer for LOAD; the next request SHALL be accepted no earlier than the edge ending WRITE+1.
REQ-026 SHALL handle dst equal to srca or srcb correctly, because the read completes before the write.
REQ-027 SHALL hold rf_wa, rf_raa, rf_rbb and rf_din at their last values when their enables are low.

Reset
REQ-028 SHALL, on Reset=1 and regardless of Clock, force state to IDLE and drive req_ready=0 while Reset is asserted.
REQ-029 SHALL, on Reset=1 and regardless of Clock, reset busy, done, rf_we, rf_rae and rf_rbe to 0.
REQ-030 SHALL, on Reset=1 and regardless of Clock, reset rf_wa, rf_raa, rf_rbb, rf_din, the latched request and the result to 0.
REQ-031 SHALL abort any operation in progress when reset is asserted, so that no rf_we pulse follows for it.
REQ-032 SHALL NOT reset register file contents.

Configuration
REQ-033 SHALL, when RF_SEQ_FLAGS_EN is defined, provide outputs zero out 1 and carry out 1, both reset to 0.
REQ-034 SHALL, with RF_SEQ_FLAGS_EN defined, update zero and carry at the edge closing WRITE: zero=(result==0); carry=ADD carry-out, or SUB borrow (a<b unsigned), and 0 for all other ops.
REQ-035 SHALL, when RF_SEQ_FLAGS_EN is undefined, omit the zero and carry ports and all flag logic, with all other behaviour identical.

Verification (REGISTER_LEN=10, RF model attached)
REQ-036 SHALL cover: LOAD dst=1 imm=0x3FF -> rf_we=1, rf_wa=1, rf_din=0x3FF one cycle after transfer; done pulses once.
REQ-037 SHALL cover: R1=0x3FF, R2=0x001, ADD dst=3 -> rf_rae=rf_rbe=1 in cycle +1, rf_din=0x000 in cycle +3; with flags, zero=1 and carry=1.
REQ-038 SHALL cover: SUB dst=0 srca=2 srcb=1 (1-0x3FF) -> rf_din=0x002 and carry=1; NOT srca=2 -> rf_din=0x3FE with rf_rbe remaining 0.
REQ-039 SHALL cover: ADD dst=1 srca=1 srcb=1 with R1=0x100 -> R1=0x200.
REQ-040 SHALL cover: req_valid held high during busy with changing op/imm -> no second acceptance until IDLE, and the in-flight result remains unchanged.
REQ-041 SHALL cover: Reset asserted in EXEC mid-cycle -> outputs go to 0 immediately, no rf_we occurs, req_ready=1 the cycle after release, and register contents are unchanged.
